// File: rtl/vga_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module   : vga_rx_monitor
// Purpose  : Recovers position from VGA HS/VS, checks timing, locks, and emits
//            coordinate-tagged pixels plus a per-frame checksum.
// Revision : 1.0
// ============================================================================
module vga_rx_monitor #(
    parameter int HPERIOD     = 800,
    parameter int HWIDTH      = 96,
    parameter int HBACK       = 48,
    parameter int HVISIBLE    = 640,
    parameter int VPERIOD     = 525,
    parameter int VWIDTH      = 2,
    parameter int VBACK       = 33,
    parameter int VVISIBLE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  VGA_R,
    input  logic [3:0]  VGA_G,
    input  logic [3:0]  VGA_B,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    output logic        LOCKED,
    output logic        PIX_VALID,
    output logic [9:0]  PIX_X,
    output logic [8:0]  PIX_Y,
    output logic [11:0] PIX_RGB,
    output logic        FRAME_DONE,
    output logic [23:0] FRAME_SUM,
    output logic [7:0]  ERR_CNT
);

    localparam logic [9:0] c_MAX       = 10'h3FF;
    localparam logic [9:0] c_HPER_M1   = 10'(HPERIOD - 1);
    localparam logic [9:0] c_HWIDTH    = 10'(HWIDTH);
    localparam logic [9:0] c_HSTART    = 10'(HWIDTH + HBACK);
    localparam logic [9:0] c_HEND      = 10'(HWIDTH + HBACK + HVISIBLE);
    localparam logic [9:0] c_VPER_M1   = 10'(VPERIOD - 1);
    localparam logic [9:0] c_VWIDTH    = 10'(VWIDTH);
    localparam logic [9:0] c_VSTART    = 10'(VWIDTH + VBACK);
    localparam logic [9:0] c_VEND      = 10'(VWIDTH + VBACK + VVISIBLE);
    localparam logic [8:0] c_VSTART9   = 9'(VWIDTH + VBACK);
    localparam logic [7:0] c_GOOD_LAST = 8'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SEARCH   = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  good_q;
    logic        in_frame_q;

    logic [11:0] rgb1_q;
    logic        hs1_q, vs1_q, hs2_q, vs2_q;
    logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d, vsw_q, vsw_d;
    logic        h_seen_q, v_seen_q, vs_seen_q, vs_pend_q, vs_pend_d;
    logic        frame_locked_q;
    logic [23:0] acc_q, acc_add_w;

    logic hs_fall_w, hs_rise_w, vs_fall_w, vs_rise_w, frame_start_w;
    logic err_w, lock_enter_w, done_w, valid_d;

    // Input stage: S1 samples the pins, S2 keeps the previous syncs for edges
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rgb1_q <= '0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
        end else begin
            rgb1_q <= {VGA_R, VGA_G, VGA_B};
            hs1_q  <= VGA_HS;
            vs1_q  <= VGA_VS;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
        end
    end

    assign hs_fall_w     = hs2_q & ~hs1_q;
    assign hs_rise_w     = ~hs2_q & hs1_q;
    assign vs_fall_w     = vs2_q & ~vs1_q;
    assign vs_rise_w     = ~vs2_q & vs1_q;
    assign frame_start_w = hs_fall_w & (vs_pend_q | vs_fall_w);

    // The _d counters describe the S1 sample currently presented
    always_comb begin
        hcnt_d = hs_fall_w ? 10'd0 : ((hcnt_q == c_MAX) ? c_MAX : hcnt_q + 10'd1);
        vcnt_d = vcnt_q;
        if (frame_start_w)
            vcnt_d = 10'd0;
        else if (hs_fall_w)
            vcnt_d = (vcnt_q == c_MAX) ? c_MAX : vcnt_q + 10'd1;
        vsw_d = vsw_q;
        if (vs_fall_w)
            vsw_d = {9'd0, hs_fall_w};
        else if (hs_fall_w && !vs1_q && vsw_q != c_MAX)
            vsw_d = vsw_q + 10'd1;
        vs_pend_d = frame_start_w ? 1'b0 : (vs_fall_w | vs_pend_q);
    end

    // Saturated counters report once; the later edge checks are suppressed
    always_comb begin
        err_w = 1'b0;
        if (hs_fall_w && h_seen_q && hcnt_q != c_MAX && hcnt_q != c_HPER_M1)
            err_w = 1'b1;
        if (hs_rise_w && h_seen_q && hcnt_q != c_MAX && hcnt_d != c_HWIDTH)
            err_w = 1'b1;
        if (!hs_fall_w && h_seen_q && hcnt_q == c_MAX - 10'd1)
            err_w = 1'b1;
        if (frame_start_w && v_seen_q && vcnt_q != c_MAX && vcnt_q != c_VPER_M1)
            err_w = 1'b1;
        if (vs_rise_w && vs_seen_q && vsw_q != c_VWIDTH)
            err_w = 1'b1;
        if (hs_fall_w && !frame_start_w && v_seen_q && vcnt_q == c_MAX - 10'd1)
            err_w = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            vsw_q     <= '0;
            h_seen_q  <= 1'b0;
            v_seen_q  <= 1'b0;
            vs_seen_q <= 1'b0;
            vs_pend_q <= 1'b0;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            vsw_q     <= vsw_d;
            vs_pend_q <= vs_pend_d;
            if (hs_fall_w)     h_seen_q  <= 1'b1;
            if (frame_start_w) v_seen_q  <= 1'b1;
            if (vs_fall_w)     vs_seen_q <= 1'b1;
        end
    end

    assign lock_enter_w = (state_q == ST_SEARCH) && frame_start_w && in_frame_q
                          && (good_q == c_GOOD_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_UNLOCKED;
            good_q     <= '0;
            in_frame_q <= 1'b0;
            LOCKED     <= 1'b0;
        end else if (err_w) begin
            state_q    <= ST_UNLOCKED;
            good_q     <= '0;
            in_frame_q <= 1'b0;
            LOCKED     <= 1'b0;
        end else begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (vs_fall_w) begin
                        state_q    <= ST_SEARCH;
                        good_q     <= '0;
                        in_frame_q <= frame_start_w;
                    end
                end
                ST_SEARCH: begin
                    if (frame_start_w) begin
                        in_frame_q <= 1'b1;
                        if (lock_enter_w) begin
                            state_q <= ST_LOCKED;
                            LOCKED  <= 1'b1;
                            good_q  <= '0;
                        end else if (in_frame_q) begin
                            good_q <= good_q + 8'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    LOCKED <= 1'b1;
                end
                default: begin
                    state_q <= ST_UNLOCKED;
                    LOCKED  <= 1'b0;
                end
            endcase
        end
    end

    assign valid_d   = (state_q == ST_LOCKED)
                       && hcnt_d >= c_HSTART && hcnt_d < c_HEND
                       && vcnt_d >= c_VSTART && vcnt_d < c_VEND;
    assign acc_add_w = PIX_VALID ? {12'd0, PIX_RGB} : 24'd0;
    assign done_w    = frame_start_w && !err_w && frame_locked_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PIX_VALID      <= 1'b0;
            PIX_X          <= '0;
            PIX_Y          <= '0;
            PIX_RGB        <= '0;
            FRAME_DONE     <= 1'b0;
            FRAME_SUM      <= '0;
            ERR_CNT        <= '0;
            acc_q          <= '0;
            frame_locked_q <= 1'b0;
        end else begin
            PIX_VALID <= valid_d;
            if (valid_d) begin
                PIX_X   <= hcnt_d - c_HSTART;
                PIX_Y   <= vcnt_d[8:0] - c_VSTART9;
                PIX_RGB <= rgb1_q;
            end
            if (err_w && ERR_CNT != 8'hFF)
                ERR_CNT <= ERR_CNT + 8'd1;
            acc_q      <= frame_start_w ? 24'd0 : acc_q + acc_add_w;
            FRAME_DONE <= done_w;
            if (done_w)
                FRAME_SUM <= acc_q + acc_add_w;
            // A frame qualifies only if it began locked and stayed error-free
            if (err_w)
                frame_locked_q <= 1'b0;
            else if (frame_start_w)
                frame_locked_q <= (state_q == ST_LOCKED) || lock_enter_w;
        end
    end

endmodule
`default_nettype wire
